// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle logic/arithmetic ops and iterative
// shift-add multiply / restoring divide that produce a double-width result.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             o,
    output logic             z,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, mag_b;
    logic             op_div, op_signed, a_neg, b_neg, div_ovf;

    // Start-cycle decode: single-cycle results and operand magnitudes
    logic [WIDTH-1:0] s_out1, s_out2, sum_add, diff, abs_a, abs_b;
    logic             s_o, is_long, sgn, is_div;

    always_comb begin
        s_out1  = '0;
        s_out2  = '0;
        s_o     = 1'b0;
        sum_add = in1 + in2;
        diff    = in1 - in2;
        sgn     = control[1];
        is_div  = control[0];
        abs_a   = (sgn && in1[WIDTH-1]) ? -in1 : in1;
        abs_b   = (sgn && in2[WIDTH-1]) ? -in2 : in2;
        // A zero divisor never enters the iteration; it finishes like a simple op.
        is_long = (control[3:2] == 2'b11) && !(is_div && (in2 == '0));
        case (control)
            4'b0000: s_out1 = in1 & in2;
            4'b0001: s_out1 = in1 | in2;
            4'b0010: s_out1 = sum_add;
            4'b0011: s_out1 = diff;
            4'b0100: s_out1 = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'b0101: s_out1 = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            4'b0111: s_out1 = ~(in1 | in2);
            4'b1010: begin
                s_out1 = sum_add;
                s_o    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_add[WIDTH-1] != in1[WIDTH-1]);
            end
            4'b1011: begin
                s_out1 = diff;
                s_o    = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            4'b1101, 4'b1111: begin
                s_out1 = '1;
                s_out2 = in1;
                s_o    = 1'b1;
            end
            default: s_o = 1'b1;
        endcase
    end

    // One iteration step of either engine, plus the sign fix-up of the final cycle
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_rem, f_q, f_r;
    logic               div_ge;
    logic [2*WIDTH-1:0] f_prod;
    logic [WIDTH-1:0]   f_out1, f_out2;
    logic               f_o, f_z;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
        f_prod    = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
        f_q       = (a_neg ^ b_neg) ? -lo : lo;
        f_r       = a_neg ? -hi : hi;
        if (op_div) begin
            f_out1 = f_q;
            f_out2 = f_r;
            f_o    = div_ovf;
            f_z    = (f_q == '0);
        end else begin
            f_out1 = f_prod[WIDTH-1:0];
            f_out2 = f_prod[2*WIDTH-1:WIDTH];
            f_o    = op_signed ? (f_out2 != {WIDTH{f_out1[WIDTH-1]}}) : (f_out2 != '0);
            f_z    = (f_out1 == '0) && (f_out2 == '0);
        end
    end

    // NOTE: every register, datapath included, is cleared by reset so an aborted op leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mag_b     <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            div_ovf   <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            o         <= 1'b0;
            z         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start && is_long) begin
                        state     <= ITER;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        hi        <= '0;
                        lo        <= is_div ? abs_a : abs_b;
                        mag_b     <= is_div ? abs_b : abs_a;
                        op_div    <= is_div;
                        op_signed <= sgn;
                        a_neg     <= sgn && in1[WIDTH-1];
                        b_neg     <= sgn && in2[WIDTH-1];
                        div_ovf   <= sgn && is_div && (in1 == {1'b1, {(WIDTH-1){1'b0}}})
                                     && (in2 == '1);
                    end else if (start) begin
                        state <= DONE;
                        done  <= 1'b1;
                        out1  <= s_out1;
                        out2  <= s_out2;
                        o     <= s_o;
                        z     <= (s_out1 == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                ITER: begin
                    if (op_div) begin
                        hi <= div_rem;
                        lo <= {lo[WIDTH-2:0], div_ge};
                    end else begin
                        {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    out1  <= f_out1;
                    out2  <= f_out2;
                    o     <= f_o;
                    z     <= f_z;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed table, corner
// sequences (start while busy, reset abort) and random ops against a model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  control;
    logic [31:0] in1, in2, out1, out2;
    logic        o, z, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .in1(in1), .in2(in2), .out1(out1), .out2(out2),
        .o(o), .z(z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        ro;
        logic        rz;
        int          lat;
    } res_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        res_t        e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      sa, sb, t, m;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '{r1: 32'd0, r2: 32'd0, ro: 1'b0, rz: 1'b0, lat: 1};
        case (c)
            4'd0:  r.r1 = a & b;
            4'd1:  r.r1 = a | b;
            4'd2:  r.r1 = a + b;
            4'd3:  r.r1 = a - b;
            4'd4:  r.r1 = {31'd0, sa < sb};
            4'd5:  r.r1 = {31'd0, a < b};
            4'd7:  r.r1 = ~(a | b);
            4'd10, 4'd11: begin
                t    = (c == 4'd10) ? sa + sb : sa - sb;
                p    = t;
                r.r1 = p[31:0];
                r.ro = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd12: begin
                p     = 64'(a) * 64'(b);
                r.r1  = p[31:0];
                r.r2  = p[63:32];
                r.ro  = (r.r2 != 0);
                r.lat = 34;
            end
            4'd14: begin
                t     = sa * sb;
                p     = t;
                r.r1  = p[31:0];
                r.r2  = p[63:32];
                r.ro  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
                r.lat = 34;
            end
            4'd13, 4'd15: begin
                if (b == 0) begin
                    r.r1 = 32'hFFFF_FFFF;
                    r.r2 = a;
                    r.ro = 1'b1;
                end else if (c == 4'd15 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.r1  = 32'h8000_0000;
                    r.ro  = 1'b1;
                    r.lat = 34;
                end else if (c == 4'd13) begin
                    r.r1  = a / b;
                    r.r2  = a % b;
                    r.lat = 34;
                end else begin
                    t     = sa / sb;
                    m     = sa % sb;
                    p     = t;
                    r.r1  = p[31:0];
                    p     = m;
                    r.r2  = p[31:0];
                    r.lat = 34;
                end
            end
            default: r.ro = 1'b1;
        endcase
        r.rz = (r.r1 == 0) && ((c == 4'd12 || c == 4'd14) ? (r.r2 == 0) : 1'b1);
        return r;
    endfunction

    // Issue one op from a negedge, optionally firing spurious starts while busy
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input res_t e, input bit noise);
        int   lat;
        logic busy1;
        control = c;
        in1     = a;
        in2     = b;
        start   = 1'b1;
        lat     = 0;
        busy1   = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) busy1 = busy;
            if (noise && lat >= 2 && lat <= 12) begin
                start   = 1'b1;
                control = 4'b0000;
                in1     = $urandom;
                in2     = $urandom;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 100);
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(e.lat));
        check({tag, " busy"}, 64'(busy1), 64'(e.lat > 1));
        check({tag, " out1"}, 64'(out1), 64'(e.r1));
        check({tag, " out2"}, 64'(out2), 64'(e.r2));
        check({tag, " o"}, 64'(o), 64'(e.ro));
        check({tag, " z"}, 64'(z), 64'(e.rz));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[18];
    logic [3:0] codes[16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd10,
                              4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd6, 4'd8, 4'd9};

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb;
        int          saw_done;

        vecs[0]  = '{4'b0000, 32'h5555_5555, 32'h0000_00F0, '{32'h0000_0050, 32'h0, 1'b0, 1'b0, 1}};
        vecs[1]  = '{4'b1010, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 32'h0, 1'b1, 1'b0, 1}};
        vecs[2]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 32'h0, 1'b0, 1'b0, 1}};
        vecs[3]  = '{4'b1011, 32'h0000_0005, 32'h0000_0005, '{32'h0, 32'h0, 1'b0, 1'b1, 1}};
        vecs[4]  = '{4'b1110, 32'hFFFF_FFFE, 32'h0000_0003, '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0, 34}};
        vecs[5]  = '{4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 34}};
        vecs[6]  = '{4'b1111, 32'hFFFF_FFF9, 32'h0000_0002, '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34}};
        vecs[7]  = '{4'b1101, 32'h0000_0007, 32'h0000_0000, '{32'hFFFF_FFFF, 32'h7, 1'b1, 1'b0, 1}};
        vecs[8]  = '{4'b0100, 32'h8000_0000, 32'h0000_0001, '{32'h1, 32'h0, 1'b0, 1'b0, 1}};
        vecs[9]  = '{4'b0101, 32'h8000_0000, 32'h0000_0001, '{32'h0, 32'h0, 1'b0, 1'b1, 1}};
        vecs[10] = '{4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h8000_0000, 32'h0, 1'b1, 1'b0, 34}};
        vecs[11] = '{4'b0110, 32'h0000_0012, 32'h0000_0034, '{32'h0, 32'h0, 1'b1, 1'b1, 1}};
        vecs[12] = '{4'b1011, 32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1}};
        vecs[13] = '{4'b0111, 32'h0000_0000, 32'h0000_0000, '{32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1}};
        vecs[14] = '{4'b0001, 32'h0000_00F0, 32'h0000_000F, '{32'h0000_00FF, 32'h0, 1'b0, 1'b0, 1}};
        vecs[15] = '{4'b1110, 32'h0000_0000, 32'h0000_0005, '{32'h0, 32'h0, 1'b0, 1'b1, 34}};
        vecs[16] = '{4'b1101, 32'h0000_0005, 32'h0000_0007, '{32'h0, 32'h5, 1'b0, 1'b1, 34}};
        vecs[17] = '{4'b1111, 32'h0000_0007, 32'hFFFF_FFFE, '{32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0, 34}};

        rst_n   = 1'b0;
        start   = 1'b0;
        control = 4'd0;
        in1     = 32'd0;
        in2     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset out1", 64'(out1), 64'd0);
        check("reset out2", 64'(out2), 64'd0);
        check("reset flags", 64'({o, z, busy, done}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d hold out1", i), 64'(out1), 64'(vecs[i].e.r1));
            check($sformatf("vec%0d hold done", i), 64'(done), 64'd0);
        end

        // Spurious starts during a MULTU must not disturb it
        run_op("busy_ignore", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               '{32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 34}, 1'b1);

        // Reset in the middle of the iteration aborts the op without a done
        control = 4'b1110;
        in1     = 32'h1234_5678;
        in2     = 32'h0000_0321;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy before reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort out1", 64'(out1), 64'd0);
        check("abort out2", 64'(out2), 64'd0);
        check("abort flags", 64'({o, z, busy, done}), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort no done", 64'(saw_done), 64'd0);
        run_op("after_abort", 4'b1110, 32'hFFFF_FFFE, 32'h0000_0003,
               model(4'b1110, 32'hFFFF_FFFE, 32'h0000_0003), 1'b0);

        // Random back-to-back ops against the model
        for (int k = 0; k < 60; k++) begin
            rc = codes[$urandom_range(0, 15)];
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rnd%0d c=%h a=%h b=%h", k, rc, ra, rb), rc, ra, rb,
                   model(rc, ra, rb), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
